// File: rtl/branch_predict_resolve_unit.sv
// Branch predict / resolve unit sitting between ID and EX.
// - ID side: 2-bit saturating-counter BHT lookup gives id_pred_taken_o.
// - EX side: resolves conditional branches from ALU flags, detects mispredicts,
//   drives the PC-mux select and pipeline flush, trains the BHT, latches halt on
//   ecall/ebreak and keeps saturating branch / mispredict statistics.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   id_pc_i, id_is_branch_i ID-stage PC and conditional-branch flag
//   id_pred_taken_o         prediction for the ID instruction
//   ex_valid_i, ex_pc_i     EX-stage valid and PC
//   ex_branch_i             EX instruction is a conditional branch
//   ex_pred_taken_i         prediction carried down with the EX instruction
//   jal_i .. fence_i        EX decode flags
//   func3_i, zf/cf/vf/sf_i  branch condition and ALU flags
//   pc_sel_o, flush_o       PC-mux select and IF/ID + ID/EX flush
//   halted_o, mispredict_o  sticky halt, current EX branch mispredicted
//   stat_branches_o         resolved conditional branches (saturating)
//   stat_mispred_o          mispredicted branches (saturating)
module branch_predict_resolve_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  id_pc_i,
  input  logic             id_is_branch_i,
  output logic             id_pred_taken_o,
  input  logic             ex_valid_i,
  input  logic [XLEN-1:0]  ex_pc_i,
  input  logic             ex_branch_i,
  input  logic             ex_pred_taken_i,
  input  logic             jal_i,
  input  logic             jalr_i,
  input  logic             ecall_i,
  input  logic             ebreak_i,
  input  logic             fence_i,
  input  logic [2:0]       func3_i,
  input  logic             zf_i,
  input  logic             cf_i,
  input  logic             vf_i,
  input  logic             sf_i,
  output logic [2:0]       pc_sel_o,
  output logic             flush_o,
  output logic             halted_o,
  output logic             mispredict_o,
  output logic [CNT_W-1:0] stat_branches_o,
  output logic [CNT_W-1:0] stat_mispred_o
);

  localparam int unsigned IdxW = $clog2(BHT_ENTRIES);
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  localparam logic [2:0] PcNext    = 3'b000;
  localparam logic [2:0] PcExTgt   = 3'b001;
  localparam logic [2:0] PcJalr    = 3'b010;
  localparam logic [2:0] PcRefetch = 3'b011;
  localparam logic [2:0] PcHold    = 3'b100;

  logic [1:0]      bht_q [BHT_ENTRIES];
  logic [1:0]      bht_entry_d;
  logic [IdxW-1:0] id_idx, ex_idx;
  logic            halted_q, halted_d;
  logic [CNT_W-1:0] stat_br_q, stat_br_d, stat_mis_q, stat_mis_d;
  logic            taken, br, mis;

  assign id_idx = id_pc_i[IdxW+1:2];
  assign ex_idx = ex_pc_i[IdxW+1:2];

  // PC bits outside the index field do not take part in prediction.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{id_pc_i[XLEN-1:IdxW+2], id_pc_i[1:0],
                            ex_pc_i[XLEN-1:IdxW+2], ex_pc_i[1:0]};

  // Lookup sees the registered table, so a same-cycle update is not visible.
  assign id_pred_taken_o = id_is_branch_i & bht_q[id_idx][1] & ~halted_q;

  always_comb begin
    taken = 1'b0;
    case (func3_i)
      3'b000:  taken = zf_i;
      3'b001:  taken = ~zf_i;
      3'b100:  taken = sf_i ^ vf_i;
      3'b101:  taken = ~(sf_i ^ vf_i);
      3'b110:  taken = ~cf_i;
      3'b111:  taken = cf_i;
      default: taken = 1'b0;
    endcase
  end

  assign br  = ex_valid_i & ex_branch_i & ~halted_q;
  assign mis = br & (taken ^ ex_pred_taken_i);

  // Outputs are forced quiet while reset is held, whatever the EX inputs do.
  assign mispredict_o = rst_n & mis;

  always_comb begin
    pc_sel_o = PcNext;
    flush_o  = 1'b0;
    if (!rst_n) begin
      pc_sel_o = PcNext;
    end else if (halted_q) begin
      pc_sel_o = PcHold;
    end else if (ex_valid_i && (ecall_i || ebreak_i)) begin
      pc_sel_o = PcHold;
      flush_o  = 1'b1;
    end else if (ex_valid_i && fence_i) begin
      pc_sel_o = PcRefetch;
      flush_o  = 1'b1;
    end else if (ex_valid_i && jal_i) begin
      pc_sel_o = PcExTgt;
      flush_o  = 1'b1;
    end else if (ex_valid_i && jalr_i) begin
      pc_sel_o = PcJalr;
      flush_o  = 1'b1;
    end else if (mis && taken) begin
      pc_sel_o = PcExTgt;
      flush_o  = 1'b1;
    end else if (mis) begin
      pc_sel_o = PcRefetch;
      flush_o  = 1'b1;
    end
  end

  always_comb begin
    bht_entry_d = bht_q[ex_idx];
    if (taken && bht_q[ex_idx] != 2'b11) begin
      bht_entry_d = bht_q[ex_idx] + 2'b01;
    end else if (!taken && bht_q[ex_idx] != 2'b00) begin
      bht_entry_d = bht_q[ex_idx] - 2'b01;
    end
  end

  assign halted_d   = halted_q | (ex_valid_i & (ecall_i | ebreak_i));
  assign stat_br_d  = (br && stat_br_q != '1) ? stat_br_q + CntOne : stat_br_q;
  assign stat_mis_d = (mis && stat_mis_q != '1) ? stat_mis_q + CntOne : stat_mis_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (br) begin
      bht_q[ex_idx] <= bht_entry_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_q   <= 1'b0;
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      halted_q   <= halted_d;
      stat_br_q  <= stat_br_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign halted_o        = halted_q;
  assign stat_branches_o = stat_br_q;
  assign stat_mispred_o  = stat_mis_q;

endmodule

// File: tb/tb_branch_predict_resolve_unit.sv
// Directed bench for branch_predict_resolve_unit (BHT_ENTRIES=64, CNT_W=4).
// Expected values are queued when a step is driven and popped when checked.
module tb_branch_predict_resolve_unit;

  localparam int unsigned CntW = 4;

  logic            clk, rst_n;
  logic [31:0]     id_pc, ex_pc;
  logic            id_is_branch, id_pred_taken;
  logic            ex_valid, ex_branch, ex_pred_taken;
  logic            jal, jalr, ecall, ebreak, fence;
  logic [2:0]      func3, pc_sel;
  logic            zf, cf, vf, sf, flush, halted, mispredict;
  logic [CntW-1:0] stat_branches, stat_mispred;

  branch_predict_resolve_unit #(
    .XLEN       (32),
    .BHT_ENTRIES(64),
    .CNT_W      (CntW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_pc_i        (id_pc),
    .id_is_branch_i (id_is_branch),
    .id_pred_taken_o(id_pred_taken),
    .ex_valid_i     (ex_valid),
    .ex_pc_i        (ex_pc),
    .ex_branch_i    (ex_branch),
    .ex_pred_taken_i(ex_pred_taken),
    .jal_i          (jal),
    .jalr_i         (jalr),
    .ecall_i        (ecall),
    .ebreak_i       (ebreak),
    .fence_i        (fence),
    .func3_i        (func3),
    .zf_i           (zf),
    .cf_i           (cf),
    .vf_i           (vf),
    .sf_i           (sf),
    .pc_sel_o       (pc_sel),
    .flush_o        (flush),
    .halted_o       (halted),
    .mispredict_o   (mispredict),
    .stat_branches_o(stat_branches),
    .stat_mispred_o (stat_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sbq.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.v) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.v);
      end
    end
  endtask

  // flg = {zf,cf,vf,sf}; ops = {jal,jalr,ecall,ebreak,fence}
  task automatic drive(input logic vld, input logic brn, input logic pt, input logic [2:0] f3,
                       input logic [3:0] flg, input logic [4:0] ops, input logic [31:0] pc);
    ex_valid = vld; ex_branch = brn; ex_pred_taken = pt; func3 = f3; ex_pc = pc;
    {zf, cf, vf, sf} = flg;
    {jal, jalr, ecall, ebreak, fence} = ops;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 4'b0000, 5'b00000, 32'h0);
  endtask

  task automatic push_out(input logic [2:0] sel, input logic fl, input logic mis);
    push("pc_sel", {29'd0, sel});
    push("flush", {31'd0, fl});
    push("mispredict", {31'd0, mis});
  endtask

  task automatic chk_out();
    chk({29'd0, pc_sel});
    chk({31'd0, flush});
    chk({31'd0, mispredict});
  endtask

  task automatic push_stats(input int b, input int m);
    push("stat_branches", b);
    push("stat_mispred", m);
  endtask

  task automatic chk_stats();
    chk({28'd0, stat_branches});
    chk({28'd0, stat_mispred});
  endtask

  // One EX step: drive after the edge, check combinational outputs on the negedge.
  task automatic step(input logic vld, input logic brn, input logic pt, input logic [2:0] f3,
                      input logic [3:0] flg, input logic [4:0] ops, input logic [31:0] pc,
                      input logic [2:0] e_sel, input logic e_fl, input logic e_mis);
    drive(vld, brn, pt, f3, flg, ops, pc);
    push_out(e_sel, e_fl, e_mis);
    @(negedge clk);
    chk_out();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic pred(input logic [31:0] pc, input logic e);
    id_pc = pc;
    id_is_branch = 1'b1;
    push("id_pred_taken", {31'd0, e});
    #1;
    chk({31'd0, id_pred_taken});
  endtask

  initial begin
    rst_n = 1'b0;
    id_pc = 32'h0;
    id_is_branch = 1'b0;
    // Reset held with a jal/ecall/mispredicting branch in EX: all outputs quiet.
    drive(1'b1, 1'b1, 1'b0, 3'b000, 4'b1000, 5'b10100, 32'h40);
    push_out(3'b000, 1'b0, 1'b0);
    push("halted_rst", 0);
    push_stats(0, 0);
    @(negedge clk);
    chk_out();
    chk({31'd0, halted});
    chk_stats();
    idle();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    pred(32'h40, 1'b0);
    // Two taken BEQs predicted not-taken: 01 -> 10 -> 11.
    step(1, 1, 0, 3'b000, 4'b1000, 5'b0, 32'h40, 3'b001, 1, 1);
    step(1, 1, 0, 3'b000, 4'b1000, 5'b0, 32'h40, 3'b001, 1, 1);
    pred(32'h40, 1'b1);
    push_stats(2, 2);
    chk_stats();

    // Three not-taken BNEs at 0x80 predicted not-taken: entry saturates at 00.
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 3'b001, 4'b1000, 5'b0, 32'h80, 3'b000, 0, 0);
    end
    pred(32'h80, 1'b0);
    // 0x180 aliases 0x80: two taken updates lift the shared entry 00 -> 01 -> 10.
    step(1, 1, 0, 3'b000, 4'b1000, 5'b0, 32'h180, 3'b001, 1, 1);
    pred(32'h80, 1'b0);
    step(1, 1, 0, 3'b000, 4'b1000, 5'b0, 32'h180, 3'b001, 1, 1);
    pred(32'h80, 1'b1);
    push_stats(7, 4);
    chk_stats();

    // BLTU with cf=1 is not taken; predicted taken -> refetch.
    step(1, 1, 1, 3'b110, 4'b0100, 5'b0, 32'h100, 3'b011, 1, 1);
    // BGE with sf=vf=1 is taken; predicted taken -> no flush.
    step(1, 1, 1, 3'b101, 4'b0011, 5'b0, 32'h104, 3'b000, 0, 0);
    push_stats(9, 5);
    chk_stats();

    // jal wins over a not-taken mispredict in the same cycle.
    step(1, 1, 1, 3'b000, 4'b0000, 5'b10000, 32'h200, 3'b001, 1, 1);
    step(1, 0, 0, 3'b000, 4'b0000, 5'b00001, 32'h204, 3'b011, 1, 0);
    step(1, 0, 0, 3'b000, 4'b0000, 5'b01000, 32'h208, 3'b010, 1, 0);
    // ex_valid=0 masks every EX flag, including a would-be mispredict.
    step(0, 1, 1, 3'b000, 4'b0000, 5'b10000, 32'h20c, 3'b000, 0, 0);
    push_stats(10, 6);
    chk_stats();

    // Read-before-write: 0x80 entry is 10; not-taken update happens this cycle.
    id_pc = 32'h80;
    id_is_branch = 1'b1;
    drive(1, 1, 1, 3'b001, 4'b1000, 5'b0, 32'h80);
    push_out(3'b011, 1, 1);
    push("id_pred_rbw", 1);
    @(negedge clk);
    chk_out();
    chk({31'd0, id_pred_taken});
    @(posedge clk);
    #1;
    idle();
    pred(32'h80, 1'b0);
    push_stats(11, 7);
    chk_stats();

    // ecall: hold + flush, then sticky halt without flush.
    step(1, 0, 0, 3'b000, 4'b0000, 5'b00100, 32'h300, 3'b100, 1, 0);
    push("halted", 1);
    chk({31'd0, halted});
    step(0, 0, 0, 3'b000, 4'b0000, 5'b0, 32'h0, 3'b100, 0, 0);
    pred(32'h40, 1'b0);
    step(1, 1, 0, 3'b000, 4'b1000, 5'b0, 32'h40, 3'b100, 0, 0);
    push_stats(11, 7);
    chk_stats();

    // Asynchronous reset between edges clears halt, stats and BHT at once.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    push("halted_async", 0);
    chk({31'd0, halted});
    push_stats(0, 0);
    chk_stats();
    pred(32'h40, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 20 mispredicted branches: both 4-bit counters saturate at 15.
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0, 3'b000, 4'b1000, 5'b0, 32'h40, 3'b001, 1, 1);
      if (i == 13) begin
        push_stats(14, 14);
        chk_stats();
      end
    end
    push_stats(15, 15);
    chk_stats();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predict_resolve_unit.md
Name: branch_predict_resolve_unit

Overview:
- Successor to the combinational branch control unit; sits between ID and EX.
- ID side: lookup in a table of 2-bit saturating counters (BHT) returns a taken/not-taken prediction for the ID-stage conditional branch.
- EX side: resolves the branch from ALU flags (BEQ/BNE/BLT/BGE/BLTU/BGEU), compares with the prediction carried down the pipe, and drives PC-mux select and flush.
- Also updates the BHT, latches halt on ecall/ebreak, and keeps saturating branch/mispredict statistics counters.

Parameters:
- XLEN, 32, PC width.
- BHT_ENTRIES, 64, number of counters; must be a power of 2 and at least 2; IDX_W = log2(BHT_ENTRIES).
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_pc  in  XLEN  PC of the instruction in ID.
- id_is_branch  in  1  ID instruction is a conditional branch.
- id_pred_taken  out  1  prediction for the ID instruction.
- ex_valid  in  1  EX holds a valid, non-bubble instruction.
- ex_pc  in  XLEN  PC of the EX instruction.
- ex_branch  in  1  EX instruction is a conditional branch (the controlSignal equivalent).
- ex_pred_taken  in  1  prediction carried to EX with the instruction.
- jal, jalr, ecall, ebreak, fence  in  1 each  EX-stage decode flags.
- func3  in  3  EX branch funct3.
- zf, cf, vf, sf  in  1 each  ALU flags.
- pc_sel  out  3  PC-mux select.
- flush  out  1  flush the IF/ID and ID/EX registers.
- halted  out  1  sticky halt state.
- mispredict  out  1  current EX branch was mispredicted.
- stat_branches  out  CNT_W  count of resolved conditional branches.
- stat_mispred  out  CNT_W  count of mispredicted branches.

Behaviour:
- Index: idx(pc) = pc[IDX_W+1:2] for both lookup and update.
- Lookup (combinational): id_pred_taken = id_is_branch & bht[idx(id_pc)][1] & ~halted.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Reset (async, rst_n=0): every BHT entry = 01; halted = 0; stat counters = 0. While in reset, pc_sel = 000, flush = 0, mispredict = 0.
- Actual outcome (taken), by func3:
  - 000: zf; 001: ~zf
  - 100: sf≠vf; 101: sf==vf
  - 110: ~cf; 111: cf
  - 010/011: not taken.
- Define br = ex_valid & ex_branch & ~halted.
- mispredict = br & (taken ≠ ex_pred_taken).
- pc_sel / flush (combinational). Priority, highest first; flush=1 only where stated:
  - 1. halted=1 → 100 (hold PC), flush=0.
  - 2. ex_valid & (ecall|ebreak) → 100, flush=1; set halted at the next edge.
  - 3. ex_valid & fence → 011 (refetch ex_pc+4), flush=1.
  - 4. ex_valid & jal → 001 (EX target), flush=1.
  - 5. ex_valid & jalr → 010 (jalr target), flush=1.
  - 6. mispredict & taken → 001, flush=1.
  - 7. mispredict & ~taken → 011, flush=1.
  - 8. otherwise → 000 (normal fetch / ID-predicted path), flush=0.
  - Correctly predicted branches never flush.
  - ex_valid=0 → no effect from any EX flag.
- BHT update, at the edge when br=1: bht[idx(ex_pc)] increments if taken, decrements if not, saturating at 11/00.
- Same-cycle lookup and update of the same index: lookup returns the pre-update value (read-before-write).
- halted: set at an edge on ex_valid&(ecall|ebreak); cleared only by rst_n. While halted: no BHT updates, no stat updates, id_pred_taken=0.
- Stats, on each edge with br=1:
  - stat_branches += 1.
  - stat_mispred += mispredict.
  - Both saturate at 2^CNT_W−1; no wrap.
- Reset asserted mid-operation clears all state immediately, regardless of clk.

Test Plan:
- Reset → lookup any id_pc with id_is_branch=1 → id_pred_taken=0; all stats 0. Two taken BEQs (zf=1, ex_pred_taken=0) at ex_pc=0x40 → both mispredict, pc_sel=001, flush=1; counter 01→10→11; then id_pc=0x40 lookup → 1.
- Counter saturation: three not-taken BNEs (zf=1) at 0x80, all predicted 0 → mispredict=0, pc_sel=000, flush=0; entry stays at 00. Aliasing check: with BHT_ENTRIES=64, ex_pc=0x80 and 0x180 update the same entry.
- Predicted-taken BLTU with cf=1 → not taken, pc_sel=011, flush=1, stat_mispred+1. Signed BGE with sf=1, vf=1 → taken.
- Priority: jal=1 with ex_branch=1 and a mispredicting flag set in the same cycle → pc_sel=001, flush=1. fence → pc_sel=011, flush=1. ex_valid=0 with jal=1 → pc_sel=000, no flush.
- ecall → pc_sel=100, flush=1; next cycle halted=1, pc_sel=100, flush=0. Further branches leave the BHT and stats unchanged. Pulse rst_n low asynchronously mid-cycle → halted=0 immediately.
- CNT_W=4: 20 resolved branches → stat_branches stays at 15 (saturated). Same-index lookup in the update cycle returns the old prediction.
